pixart_sequencer: RTL and testbench

- Sequences the Pixart IR camera over a transaction-level I2C master: one init register-write sequence, then periodic 16-byte blob reads.
- Decodes blob 1 into 10-bit x/y, which feed the LED/position logic.
- Replaces manual button-triggered single transactions with an autonomous, error-recovering schedule.
- Runs on the slow I2C-domain clock.

---
 rtl/pixart_sequencer.sv | 148 ++++++++++++++
 tb/tb_pixart_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pixart_sequencer.sv
// pixart_sequencer: autonomous init-then-poll scheduler for the Pixart IR camera over a
// transaction-level I2C master; decodes blob 1 into 10-bit x/y.
module pixart_sequencer #(
  parameter int INIT_GAP    = 1000,
  parameter int POLL_PERIOD = 5000,
  parameter int RETRY_GAP   = 20000,
  parameter int READ_BYTES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       i2c_req,
  output logic       i2c_rw,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_err,
  input  logic       i2c_rvalid,
  input  logic [7:0] i2c_rdata,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       blob_valid,
  output logic       frame_tick,
  output logic       init_done,
  output logic [7:0] err_count
);
  typedef enum logic [3:0] {
    S_IDLE, S_INIT_REQ, S_INIT_WAIT, S_INIT_GAP, S_RD_REQ, S_RD_WAIT, S_UPDATE, S_POLL_WAIT, S_ERROR
  } state_t;
  localparam logic [15:0] IG = 16'(INIT_GAP - 1);
  localparam logic [15:0] PP = 16'(POLL_PERIOD - 1);
  localparam logic [15:0] RG = 16'(RETRY_GAP - 1);
  localparam logic [7:0]  RB = 8'(READ_BYTES);
  state_t      state;
  logic [2:0]  idx;
  logic [15:0] cnt;
  logic [7:0]  bcnt, bcnt_n, xl, yl, s, err_inc;
  logic [15:0] init_word;
  always_comb begin
    init_word = idx == 3'd0 ? 16'h3001 : idx == 3'd1 ? 16'h3008 : idx == 3'd2 ? 16'h0690 :
                idx == 3'd3 ? 16'h08C0 : idx == 3'd4 ? 16'h1A40 : 16'h3333;
    bcnt_n    = (i2c_rvalid && bcnt < RB) ? bcnt + 8'd1 : bcnt;
    err_inc   = err_count + {7'd0, err_count != 8'hFF};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      bcnt       <= '0;
      xl         <= '0;
      yl         <= '0;
      s          <= '0;
      i2c_req    <= 1'b0;
      i2c_rw     <= 1'b0;
      i2c_reg    <= '0;
      i2c_wdata  <= '0;
      x          <= '0;
      y          <= '0;
      blob_valid <= 1'b0;
      frame_tick <= 1'b0;
      init_done  <= 1'b0;
      err_count  <= '0;
    end else begin
      i2c_req    <= 1'b0;
      frame_tick <= 1'b0;
      cnt        <= cnt + 16'd1;
      // Disable only parks from states with no transaction in flight.
      if (!enable && state inside {S_INIT_REQ, S_INIT_GAP, S_RD_REQ, S_POLL_WAIT, S_ERROR}) begin
        state     <= S_IDLE;
        init_done <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (enable) begin
            idx   <= '0;
            state <= S_INIT_REQ;
          end
          S_INIT_REQ: if (!i2c_busy) begin
            i2c_req                <= 1'b1;
            i2c_rw                 <= 1'b0;
            {i2c_reg, i2c_wdata}   <= init_word;
            state                  <= S_INIT_WAIT;
          end
          S_INIT_WAIT: if (i2c_done) begin
            cnt <= '0;
            if (i2c_err) begin
              err_count <= err_inc;
              init_done <= 1'b0;
              state     <= S_ERROR;
            end else state <= S_INIT_GAP;
          end
          S_INIT_GAP: if (cnt == IG) begin
            if (idx == 3'd5) begin
              init_done <= 1'b1;
              state     <= S_RD_REQ;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_INIT_REQ;
            end
          end
          S_RD_REQ: if (!i2c_busy) begin
            i2c_req   <= 1'b1;
            i2c_rw    <= 1'b1;
            i2c_reg   <= 8'h36;
            i2c_wdata <= 8'h00;
            bcnt      <= '0;
            state     <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            bcnt <= bcnt_n;
            if (i2c_rvalid && bcnt < RB) begin
              if (bcnt == 8'd1) xl <= i2c_rdata;
              if (bcnt == 8'd2) yl <= i2c_rdata;
              if (bcnt == 8'd3) s  <= i2c_rdata;
            end
            // A read too short to contain blob 1 is handled like a NACK.
            if (i2c_done) begin
              cnt <= '0;
              if (i2c_err || bcnt_n < 8'd4) begin
                err_count <= err_inc;
                init_done <= 1'b0;
                state     <= S_ERROR;
              end else state <= S_UPDATE;
            end
          end
          S_UPDATE: begin
            frame_tick <= 1'b1;
            cnt        <= '0;
            state      <= S_POLL_WAIT;
            if ({s, xl, yl} == 24'hFFFFFF) blob_valid <= 1'b0;
            else begin
              x          <= {s[5:4], xl};
              y          <= {s[7:6], yl};
              blob_valid <= 1'b1;
            end
          end
          S_POLL_WAIT: if (cnt == PP) state <= S_RD_REQ;
          S_ERROR: if (cnt == RG) begin
            idx   <= '0;
            state <= S_INIT_REQ;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pixart_sequencer.sv
// tb_pixart_sequencer: directed bench with an inline zero-latency I2C master model.
module tb_pixart_sequencer;
  localparam int IG = 8;
  localparam int PP = 30;
  localparam int RG = 60;
  localparam int RB = 16;
  localparam int LIMIT = 2 * RG + 200;
  logic [15:0] tbl [6] = '{16'h3001, 16'h3008, 16'h0690, 16'h08C0, 16'h1A40, 16'h3333};

  logic       clk = 1'b0;
  logic       reset, enable, i2c_busy, i2c_done, i2c_err, i2c_rvalid;
  logic [7:0] i2c_rdata;
  logic       i2c_req, i2c_rw, blob_valid, frame_tick, init_done;
  logic [7:0] i2c_reg, i2c_wdata, err_count;
  logic [9:0] x, y;
  logic [48:0] outs;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_done = 0;
  int n;

  pixart_sequencer #(.INIT_GAP(IG), .POLL_PERIOD(PP), .RETRY_GAP(RG), .READ_BYTES(RB)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .i2c_req(i2c_req), .i2c_rw(i2c_rw), .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_err(i2c_err),
    .i2c_rvalid(i2c_rvalid), .i2c_rdata(i2c_rdata),
    .x(x), .y(y), .blob_valid(blob_valid), .frame_tick(frame_tick),
    .init_done(init_done), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign outs = {i2c_req, i2c_rw, i2c_reg, i2c_wdata, x, y, blob_valid, frame_tick, init_done, err_count};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a request; when hi > 0 also checks the distance from the last done.
  task automatic wait_req(input string tag, input int lo, input int hi);
    int k = 0;
    int gap;
    while (i2c_req !== 1'b1 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_seen"}, {63'd0, i2c_req}, 64'd1);
    if (hi > 0) begin
      gap = cyc - t_done;
      vectors++;
      assert (gap >= lo && gap <= hi) else begin
        miscompares++;
        $error("FAIL %s_gap: observed %0d expected %0d..%0d", tag, gap, lo, hi);
      end
    end
  endtask

  task automatic do_write(input string tag, input logic [7:0] r, input logic [7:0] d,
                          input bit nack, input int lo, input int hi);
    wait_req(tag, lo, hi);
    chk({tag, "_fields"}, {47'd0, i2c_rw, i2c_reg, i2c_wdata}, {47'd0, 1'b0, r, d});
    i2c_done = 1'b1;
    i2c_err  = nack;
    t_done   = cyc;
    @(negedge clk);
    chk({tag, "_pulse"}, {63'd0, i2c_req}, 64'd0);
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input bit nack, input bit drop_en,
                         input int lo, input int hi, input logic bv, input logic [9:0] xe,
                         input logic [9:0] ye);
    int k = 0;
    wait_req(tag, lo, hi);
    chk({tag, "_fields"}, {47'd0, i2c_rw, i2c_reg, i2c_wdata}, {47'd0, 1'b1, 8'h36, 8'h00});
    if (drop_en) enable = 1'b0;
    // Extra bytes past READ_BYTES are all-ones and must be ignored.
    for (int i = 0; i < RB + 4; i++) begin
      i2c_rvalid = 1'b1;
      i2c_rdata  = i == 0 ? b0 : i == 1 ? b1 : i == 2 ? b2 : i == 3 ? b3 : i >= RB ? 8'hFF : 8'hEE;
      @(negedge clk);
      if (i == 0) chk({tag, "_pulse"}, {63'd0, i2c_req}, 64'd0);
    end
    i2c_rvalid = 1'b0;
    i2c_done   = 1'b1;
    i2c_err    = nack;
    t_done     = cyc;
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
    if (!nack) begin
      while (frame_tick !== 1'b1 && k < 4) begin
        @(negedge clk);
        k++;
      end
      chk({tag, "_tick"}, {63'd0, frame_tick}, 64'd1);
      chk({tag, "_xy"}, {43'd0, blob_valid, x, y}, {43'd0, bv, xe, ye});
      @(negedge clk);
      chk({tag, "_tick_end"}, {63'd0, frame_tick}, 64'd0);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; i2c_busy = 1'b0; i2c_done = 1'b0; i2c_err = 1'b0;
    i2c_rvalid = 1'b0; i2c_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_vals", {15'd0, outs}, 64'd0);
    reset = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (i2c_req) n++;
    end
    chk("disabled_no_req", 64'(n), 64'd0);
    enable = 1'b1;
    for (int i = 0; i < 6; i++)
      do_write("init", tbl[i][15:8], tbl[i][7:0], 1'b0, i == 0 ? 0 : IG, i == 0 ? 0 : IG + 4);
    chk("init_done_pre", {63'd0, init_done}, 64'd0);
    // s=0x65: x={10,0x34}, y={01,0x12}
    do_read("rd1", 8'h5A, 8'h34, 8'h12, 8'h65, 1'b0, 1'b0, IG, IG + 4, 1'b1, 10'h234, 10'h112);
    chk("init_done_post", {63'd0, init_done}, 64'd1);
    repeat (5) @(negedge clk);
    i2c_done = 1'b1;
    i2c_err  = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
    do_read("rd_noblob", 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, PP, PP + 4, 1'b0, 10'h234, 10'h112);
    chk("stray_done_ignored", {56'd0, err_count}, 64'd0);
    // s=0x9C: x={01,0x0F}, y={10,0xA0}
    do_read("rd3", 8'h00, 8'h0F, 8'hA0, 8'h9C, 1'b0, 1'b0, PP, PP + 4, 1'b1, 10'h10F, 10'h2A0);
    do_read("rd_nack", 8'h00, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0, PP, PP + 4, 1'b0, 10'h0, 10'h0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_tick) n++;
    end
    chk("rd_nack_no_tick", 64'(n), 64'd0);
    chk("rd_nack_state", {33'd0, init_done, err_count, blob_valid, x, y},
        {33'd0, 1'b0, 8'd1, 1'b1, 10'h10F, 10'h2A0});
    do_write("retry1", 8'h30, 8'h01, 1'b0, RG, RG + 4);
    do_write("w1", 8'h30, 8'h08, 1'b0, IG, IG + 4);
    do_write("w2_nack", 8'h06, 8'h90, 1'b1, IG, IG + 4);
    @(negedge clk);
    chk("w2_nack_state", {55'd0, init_done, err_count}, {55'd0, 1'b0, 8'd2});
    do_write("retry2", 8'h30, 8'h01, 1'b0, RG, RG + 4);
    for (int i = 1; i < 6; i++) do_write("reinit", tbl[i][15:8], tbl[i][7:0], 1'b0, IG, IG + 4);
    i2c_busy = 1'b1;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (i2c_req) n++;
    end
    chk("busy_no_req", 64'(n), 64'd0);
    i2c_busy = 1'b0;
    // s=0x30: x={11,0x80}, y={00,0x40}; enable drops mid-read
    do_read("rd_drop", 8'h00, 8'h80, 8'h40, 8'h30, 1'b0, 1'b1, 0, 0, 1'b1, 10'h380, 10'h040);
    n = 0;
    repeat (3 * PP + 20) begin
      @(negedge clk);
      if (i2c_req) n++;
    end
    chk("parked_no_req", 64'(n), 64'd0);
    chk("parked_init_done", {63'd0, init_done}, 64'd0);
    enable = 1'b1;
    for (int i = 0; i < 6; i++)
      do_write("reenable", tbl[i][15:8], tbl[i][7:0], 1'b0, i == 0 ? 0 : IG, i == 0 ? 0 : IG + 4);
    wait_req("rd_rst", IG, IG + 4);
    for (int i = 0; i < 2; i++) begin
      i2c_rvalid = 1'b1;
      i2c_rdata  = 8'h55;
      @(negedge clk);
    end
    i2c_rvalid = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_mid_read", {15'd0, outs}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    do_write("post_rst", 8'h30, 8'h01, 1'b1, 0, 0);
    for (int i = 0; i < 255; i++) do_write("sat", 8'h30, 8'h01, 1'b1, RG, RG + 4);
    @(negedge clk);
    chk("err_count_sat", {56'd0, err_count}, 64'd255);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
